fft_twiddle_sequencer: RTL

Streams radix-2 DIT FFT butterfly schedules for one FFT pass, one butterfly per handshake.
Each beat carries the stage index, the top/bottom data addresses and the complex twiddle factor W = cos − j·sin.
The twiddle is taken from the sine-wave twiddle table (SIZE_FFT entries, fixed point).
Sits between the FFT top-level control and the butterfly datapath/memory address logic.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_twiddle_index_calc.sv | 33 +++
 rtl/fft_twiddle_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer states, log2 helper, fixed-point defaults.
// Optional feature macro FFT_TWIDDLE_INVERSE_EN is consumed by fft_twiddle_sequencer.
package fft_pkg;

  localparam int FFT_BIT_WIDTH     = 32;
  localparam int FFT_DECIMAL_POINT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fft_state_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int v = n; v > 1; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fft_twiddle_index_calc.sv
// Radix-2 DIT butterfly index map: (stage, butterfly) -> top/bottom
// addresses and twiddle table index.
module fft_twiddle_index_calc #(
  parameter int L  = 7,
  parameter int SW = 3
) (
  input  logic [SW-1:0] s,
  input  logic [L-2:0]  j,
  output logic [L-1:0]  addr_top,
  output logic [L-1:0]  addr_bot,
  output logic [L-1:0]  tw_idx
);

  localparam logic [L-1:0]  ONE   = 1;
  localparam logic [SW-1:0] S_TOP = SW'(L - 1);

  logic [L-1:0] jw;
  logic [L-1:0] half;
  logic [L-1:0] k;
  logic [L-1:0] g;

  always_comb begin
    jw       = {1'b0, j};
    half     = ONE << s;
    k        = jw & (half - ONE);
    g        = jw >> s;
    // shift twice: s+1 can overflow the stage field
    addr_top = ((g << s) << 1) | k;
    addr_bot = addr_top + half;
    tw_idx   = k << (S_TOP - s);
  end

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// Streams one pass of radix-2 DIT butterfly beats with table twiddles.
// Define FFT_TWIDDLE_INVERSE_EN to add the inverse (conjugate twiddle) input.
module fft_twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH     = FFT_BIT_WIDTH,
  parameter int DECIMAL_POINT = FFT_DECIMAL_POINT,
  parameter int SIZE_FFT      = 128,
  localparam int L  = log2(SIZE_FFT),
  localparam int SW = $clog2(L)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] sine_wave_in [0:SIZE_FFT-1],
  input  logic                 start,
`ifdef FFT_TWIDDLE_INVERSE_EN
  input  logic                 inverse,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_stage,
  output logic [L-1:0]         out_addr_top,
  output logic [L-1:0]         out_addr_bot,
  output logic [BIT_WIDTH-1:0] out_tw_real,
  output logic [BIT_WIDTH-1:0] out_tw_imag
);

  localparam logic [SW-1:0] S_ONE  = 1;
  localparam logic [SW-1:0] S_LAST = SW'(L - 1);
  localparam logic [L-2:0]  J_ONE  = 1;
  localparam logic [L-2:0]  J_LAST = '1;
  localparam logic [L-1:0]  QUART  = L'(SIZE_FFT / 4);

  if (DECIMAL_POINT >= BIT_WIDTH - 1) begin : g_bad_fmt
    $error("DECIMAL_POINT leaves no room for +1.0");
  end

  fft_state_t    state, state_nxt;
  logic [SW-1:0] s, s_nxt;
  logic [L-2:0]  j, j_nxt;
  logic          xfer;
  logic          last;
  logic          load;
  logic          neg;
  logic [L-1:0]  top_c;
  logic [L-1:0]  bot_c;
  logic [L-1:0]  idx_c;
  logic [L-1:0]  cos_idx;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign out_valid = (state == RUN);
  assign xfer      = out_valid & out_ready;
  assign last      = (s == S_LAST) && (j == J_LAST);
  assign cos_idx   = idx_c + QUART;

`ifdef FFT_TWIDDLE_INVERSE_EN
  logic inv_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_q <= 1'b0;
    end else if (state == IDLE && start) begin
      inv_q <= inverse;
    end
  end

  // first beat loads in the same edge that latches inverse
  assign neg = !((state == IDLE) ? inverse : inv_q);
`else
  assign neg = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    j_nxt     = j;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          j_nxt     = '0;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            load = 1'b1;
            if (j == J_LAST) begin
              j_nxt = '0;
              s_nxt = s + S_ONE;
            end else begin
              j_nxt = j + J_ONE;
            end
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  fft_twiddle_index_calc #(
    .L  (L),
    .SW (SW)
  ) u_index (
    .s        (s_nxt),
    .j        (j_nxt),
    .addr_top (top_c),
    .addr_bot (bot_c),
    .tw_idx   (idx_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s     <= '0;
      j     <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      j     <= j_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_stage    <= '0;
      out_addr_top <= '0;
      out_addr_bot <= '0;
      out_tw_real  <= '0;
      out_tw_imag  <= '0;
    end else if (load) begin
      out_stage    <= s_nxt;
      out_addr_top <= top_c;
      out_addr_bot <= bot_c;
      out_tw_real  <= sine_wave_in[cos_idx];
      out_tw_imag  <= neg ? -sine_wave_in[idx_c]
                          : sine_wave_in[idx_c];
    end
  end

endmodule
